ce_synth_multi: RTL and testbench

//  Multi-channel fractional clock-enable synthesiser. It is the parametrised successor to the fixed single-output
//  PLL wrapper: one refclk domain and no extra PLL outputs. Each channel runs a phase accumulator (DDS) and emits
//  a one-cycle enable plus a ~50% square wave at an arbitrary refclk fraction, e.g. the 1.76 MHz CPU enable from 50 MHz.
//  The system clock can be reprogrammed at runtime without glitches, with a per-channel lock indication.

---
 rtl/ce_synth_multi.sv | 131 +++++++++++++
 tb/tb_ce_synth_multi.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ce_synth_multi.sv
// Multi-channel fractional clock-enable synthesiser. Each channel runs a phase
// accumulator and reloads its increment only at a phase-0 boundary, so output rates change without glitches.
//
// state   | meaning
// ST_IDLE | run low, accumulator held at zero, outputs low
// ST_RUN  | run high, no increment update waiting
// ST_PEND | new increment latched, waiting for the next wrap (or next edge if idle/frozen)

module ce_synth_multi #(
    parameter int NUM_CH      = 2,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 16,
    parameter logic [NUM_CH*ACC_W-1:0] DEFAULT_INC = {NUM_CH{ACC_W'(151182849)}},
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] run_i,
    input  logic              cfg_wr_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [ACC_W-1:0]  cfg_inc_i,
    output logic              cfg_ready_o,
    output logic [NUM_CH-1:0] ce_out_o,
    output logic [NUM_CH-1:0] clk_sq_o,
    output logic [NUM_CH-1:0] locked_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PEND
    } state_t;

    localparam logic [7:0] LOCK_N = 8'(LOCK_CYCLES);

    logic [NUM_CH-1:0] ch_sel;
    logic [NUM_CH-1:0] ch_pend;

    // An out-of-range cfg_ch selects no channel, so it is never ready.
    assign cfg_ready_o = |(ch_sel & ~ch_pend);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t           state_q, state_d;
        logic [ACC_W-1:0] acc_q, acc_d;
        logic [ACC_W-1:0] inc_q, inc_d;
        logic [ACC_W-1:0] pinc_q, pinc_d;
        logic [7:0]       cnt_q, cnt_d;
        logic             ce_q, ce_d;
        logic             sq_q, sq_d;
        logic             lk_q, lk_d;
        logic [ACC_W:0]   sum;
        logic             carry;
        logic             pend;
        logic             accept;
        logic             apply;

        assign ch_sel[g]  = (cfg_ch_i == CH_W'(g));
        assign pend       = (state_q == ST_PEND);
        assign ch_pend[g] = pend;
        assign accept     = cfg_wr_i && ch_sel[g] && !pend;
        assign sum        = {1'b0, acc_q} + {1'b0, inc_q};
        assign carry      = sum[ACC_W];
        // A stopped or frozen channel has no wrap to wait for.
        assign apply      = pend && (!run_i[g] || (inc_q == '0) || carry);

        always_comb begin
            state_d = state_q;
            acc_d   = acc_q;
            inc_d   = inc_q;
            pinc_d  = pinc_q;
            cnt_d   = cnt_q;
            ce_d    = 1'b0;
            sq_d    = 1'b0;
            lk_d    = 1'b0;

            if (run_i[g]) begin
                acc_d = sum[ACC_W-1:0];
                ce_d  = carry;
                sq_d  = sum[ACC_W-1];
                lk_d  = (cnt_q == LOCK_N);
                if (carry && (cnt_q != LOCK_N)) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end else begin
                acc_d = '0;
                cnt_d = '0;
            end

            if (apply) begin
                inc_d = pinc_q;
                cnt_d = '0;
                lk_d  = 1'b0;
            end

            state_d = run_i[g] ? ST_RUN : ST_IDLE;
            if (accept) begin
                pinc_d  = cfg_inc_i;
                state_d = ST_PEND;
            end else if (pend && !apply) begin
                state_d = ST_PEND;
            end
        end

        always_ff @(posedge refclk_i) begin
            if (rst_i) begin
                state_q <= ST_IDLE;
                acc_q   <= '0;
                inc_q   <= DEFAULT_INC[g*ACC_W +: ACC_W];
                pinc_q  <= '0;
                cnt_q   <= '0;
                ce_q    <= 1'b0;
                sq_q    <= 1'b0;
                lk_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                acc_q   <= acc_d;
                inc_q   <= inc_d;
                pinc_q  <= pinc_d;
                cnt_q   <= cnt_d;
                ce_q    <= ce_d;
                sq_q    <= sq_d;
                lk_q    <= lk_d;
            end
        end

        assign ce_out_o[g] = ce_q;
        assign clk_sq_o[g] = sq_q;
        assign locked_o[g] = lk_q;
    end

endmodule

// File: tb/tb_ce_synth_multi.sv
// Bench for ce_synth_multi: an 8-bit two-channel instance checked every cycle
// against an arithmetic model, plus a 32-bit single-channel instance for long-run rate.

module tb_ce_synth_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, wr8, rdy8;
    logic [1:0] run8, ce8, sq8, lk8;
    logic [0:0] ch8;
    logic [7:0] inc8;

    ce_synth_multi #(
        .NUM_CH(2), .ACC_W(8), .LOCK_CYCLES(4), .DEFAULT_INC({8'd32, 8'd64})
    ) dut8 (
        .refclk_i(clk), .rst_i(rst8), .run_i(run8), .cfg_wr_i(wr8), .cfg_ch_i(ch8),
        .cfg_inc_i(inc8), .cfg_ready_o(rdy8), .ce_out_o(ce8), .clk_sq_o(sq8), .locked_o(lk8)
    );

    logic        rst32, wr32, rdy32;
    logic [0:0]  run32, ce32, sq32, lk32, ch32;
    logic [31:0] inc32;

    ce_synth_multi #(
        .NUM_CH(1), .ACC_W(32), .LOCK_CYCLES(16)
    ) dut32 (
        .refclk_i(clk), .rst_i(rst32), .run_i(run32), .cfg_wr_i(wr32), .cfg_ch_i(ch32),
        .cfg_inc_i(inc32), .cfg_ready_o(rdy32), .ce_out_o(ce32), .clk_sq_o(sq32), .locked_o(lk32)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model for dut8: modulus-256 phase arithmetic per channel.
    localparam int M     = 256;
    localparam int LOCKN = 4;
    int   m_phase[2];
    int   m_inc[2];
    int   m_pinc[2];
    int   m_pulses[2];
    bit   m_pend[2];
    logic [1:0] e_ce, e_sq, e_lk;
    bit   m_valid = 1'b0;

    task automatic model_step();
        bit was, take, frozen, wrap;
        int s;
        if (rst8) begin
            for (int c = 0; c < 2; c++) begin
                m_phase[c]  = 0;
                m_pend[c]   = 1'b0;
                m_pinc[c]   = 0;
                m_pulses[c] = 0;
            end
            m_inc[0] = 64;
            m_inc[1] = 32;
            e_ce = '0; e_sq = '0; e_lk = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            for (int c = 0; c < 2; c++) begin
                was    = m_pend[c];
                take   = wr8 && (int'(ch8) == c) && !was;
                frozen = (m_inc[c] == 0);
                wrap   = 1'b0;
                if (!run8[c]) begin
                    m_phase[c]  = 0;
                    m_pulses[c] = 0;
                    e_ce[c] = 1'b0; e_sq[c] = 1'b0; e_lk[c] = 1'b0;
                end else begin
                    s          = m_phase[c] + m_inc[c];
                    wrap       = (s >= M);
                    m_phase[c] = s % M;
                    e_ce[c]    = wrap;
                    e_sq[c]    = (m_phase[c] >= M / 2);
                    e_lk[c]    = (m_pulses[c] >= LOCKN);
                    if (wrap) m_pulses[c]++;
                end
                if (was && (!run8[c] || frozen || wrap)) begin
                    m_inc[c]    = m_pinc[c];
                    m_pend[c]   = 1'b0;
                    m_pulses[c] = 0;
                    e_lk[c]     = 1'b0;
                end
                if (take) begin
                    m_pend[c] = 1'b1;
                    m_pinc[c] = int'(inc8);
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (m_valid) begin
                chk("m_ce8", 64'(ce8), 64'(e_ce));
                chk("m_sq8", 64'(sq8), 64'(e_sq));
                chk("m_lk8", 64'(lk8), 64'(e_lk));
                chk("m_rdy8", 64'(rdy8), 64'(!m_pend[ch8]));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    int n0, n1, nsq0, nsq1, fl0, fl1, first, n;
    logic [127:0] ce0v, lk0v;

    initial begin
        rst8 = 1'b1; run8 = '0; wr8 = 1'b0; ch8 = '0; inc8 = '0;
        rst32 = 1'b1; run32 = '0; wr32 = 1'b0; ch32 = '0; inc32 = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_out8", 64'({ce8, sq8, lk8}), 64'd0);
        chk("rst_rdy8", 64'(rdy8), 64'd1);
        chk("rst_out32", 64'({ce32, sq32, lk32}), 64'd0);

        // T1/T2: default rates and lock timing
        tick();
        rst8 = 1'b0; run8 = 2'b11;
        n0 = 0; n1 = 0; nsq0 = 0; nsq1 = 0; fl0 = -1; fl1 = -1; ce0v = '0; lk0v = '0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            @(negedge clk);
            ce0v[k] = ce8[0];
            n0 += int'(ce8[0]); n1 += int'(ce8[1]);
            nsq0 += int'(sq8[0]); nsq1 += int'(sq8[1]);
            if (lk8[0] && fl0 < 0) fl0 = k;
            if (lk8[1] && fl1 < 0) fl1 = k;
        end
        chk("t1_ce0_count", 64'(n0), 64'd10);
        chk("t1_ce1_count", 64'(n1), 64'd5);
        chk("t1_sq0_high", 64'(nsq0), 64'd20);
        chk("t1_sq1_high", 64'(nsq1), 64'd20);
        chk("t1_ce0_c3_c4", 64'({ce0v[3], ce0v[4]}), 64'd1);
        chk("t2_lock0_cycle", 64'(fl0), 64'd17);
        chk("t2_lock1_cycle", 64'(fl1), 64'd33);

        // T3/T4: reprogram ch0 to 128 mid-period, then an ignored write of 16
        tick();
        wr8 = 1'b1; ch8 = 1'b0; inc8 = 8'd128;
        @(negedge clk);
        chk("t3_rdy_before", 64'(rdy8), 64'd1);
        tick();
        inc8 = 8'd16;
        @(negedge clk);
        chk("t3_rdy_pending", 64'(rdy8), 64'd0);
        tick();
        wr8 = 1'b0;
        ce0v = '0; lk0v = '0; fl0 = -1; n = 0;
        for (int k = 43; k <= 60; k++) begin
            @(negedge clk);
            ce0v[k] = ce8[0];
            lk0v[k] = lk8[0];
            if (k == 43) chk("t3_rdy_43", 64'(rdy8), 64'd0);
            if (k == 44) chk("t3_rdy_44", 64'(rdy8), 64'd1);
            if (k > 44 && lk8[0] && fl0 < 0) fl0 = k;
            if (k > 44) n += int'(ce8[0]);
            tick();
        end
        chk("t3_ce0_44to48", 64'({ce0v[44], ce0v[45], ce0v[46], ce0v[47], ce0v[48]}), 64'b10101);
        chk("t3_lk0_43_44", 64'({lk0v[43], lk0v[44]}), 64'b10);
        chk("t3_relock_cycle", 64'(fl0), 64'd53);
        chk("t4_rate128_pulses", 64'(n), 64'd8);

        // T5: stop ch1, reprogram while idle, restart
        run8 = 2'b01;
        tick();
        wr8 = 1'b1; ch8 = 1'b1; inc8 = 8'd64;
        @(negedge clk);
        chk("t5_ch1_idle", 64'({ce8[1], sq8[1], lk8[1]}), 64'd0);
        tick();
        wr8 = 1'b0;
        tick();
        run8 = 2'b11;
        first = -1; n = 0;
        for (int k = 65; k <= 80; k++) begin
            tick();
            @(negedge clk);
            if (ce8[1] && first < 0) first = k;
            n += int'(ce8[1]);
        end
        chk("t5_first_ce1", 64'(first), 64'd68);
        chk("t5_ce1_count", 64'(n), 64'd4);

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst8 = ($urandom_range(0, 599) == 0);
            wr8  = ($urandom_range(0, 3) == 0);
            ch8  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       inc8 = 8'd0;
                1:       inc8 = 8'd255;
                2:       inc8 = 8'd128;
                default: inc8 = 8'($urandom_range(1, 254));
            endcase
            for (int b = 0; b < 2; b++)
                if ($urandom_range(0, 63) == 0) run8[b] = ~run8[b];
        end
        tick();
        rst8 = 1'b0; run8 = 2'b11; wr8 = 1'b1; ch8 = 1'b0; inc8 = 8'd200;
        tick();
        wr8 = 1'b0; rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        @(negedge clk);
        chk("rst_mid8", 64'({ce8, sq8, lk8}), 64'd0);

        // T6: long-run rate of the 32-bit default increment
        tick();
        rst32 = 1'b0; run32 = 1'b1;
        n = 0; first = -1;
        for (int k = 1; k <= 50000; k++) begin
            tick();
            @(negedge clk);
            n += int'(ce32);
            if (ce32 && first < 0) first = k;
        end
        checks++;
        if (n < 1759 || n > 1761) begin
            failures++;
            $display("FAIL t6_pulse_count actual=%0d required=1760+-1", n);
        end
        chk("t6_first_ce", 64'(first), 64'd29);
        chk("t6_locked", 64'(lk32), 64'd1);

        ch32 = 1'b1;
        @(negedge clk);
        chk("t6_rdy_out_of_range", 64'(rdy32), 64'd0);
        tick();
        ch32 = 1'b0; wr32 = 1'b1; inc32 = 32'h8000_0000;
        @(negedge clk);
        chk("t6_rdy_ch0", 64'(rdy32), 64'd1);
        tick();
        wr32 = 1'b0;
        @(negedge clk);
        chk("t6_rdy_pending", 64'(rdy32), 64'd0);
        tick();
        rst32 = 1'b1;
        tick();
        rst32 = 1'b0;
        @(negedge clk);
        chk("t6_rst_out", 64'({ce32, sq32, lk32}), 64'd0);
        chk("t6_rst_rdy", 64'(rdy32), 64'd1);
        first = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            @(negedge clk);
            if (ce32 && first < 0) first = k;
        end
        chk("t6_default_restored", 64'(first), 64'd29);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
